// File: rtl/adc_seq_ctrl.sv
// Conversion sequencer and simultaneous A/B serial reader for the memboard dual-channel ADC.
// Optional build macro ADC_SEQ_TESTPAT_EN replaces the serial data with a sample-index test pattern.

module adc_seq_ctrl #(
  parameter int DATA_BITS    = 14,
  parameter int SCLK_DIV     = 4,
  parameter int CNVST_LOW    = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          n_samples,
  input  logic [15:0]          interval,
  output logic                 running,
  output logic                 done,
  output logic                 error,
  output logic                 CNVST_ADC,
  output logic                 CS_ADC,
  output logic                 SCLK_ADC,
  input  logic                 BUSY_ADC,
  input  logic                 DOUTA_ADC,
  input  logic                 DOUTB_ADC,
  output logic [DATA_BITS-1:0] data_a,
  output logic [DATA_BITS-1:0] data_b,
  output logic                 data_valid,
  input  logic                 data_ready
);

  localparam int TMR_MAX = (BUSY_TIMEOUT > CNVST_LOW) ? BUSY_TIMEOUT : CNVST_LOW;
  localparam int TMO_W   = $clog2(TMR_MAX + 1);
  localparam int DIV_W   = $clog2(SCLK_DIV);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT_BH, WAIT_BL, SHIFT, OUT, GAP, DONE} state_t;

  state_t             state;
  logic               busy_meta, busy_sync;
  logic [15:0]        rem;
  logic [15:0]        ivl_len, ivl_cnt;
  logic [15:0]        ivl_sel, ivl_reload;
  logic [TMO_W-1:0]   tmr;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               setup;
`ifdef ADC_SEQ_TESTPAT_EN
  logic [15:0]        sample_idx;
`else
  logic [DATA_BITS-1:0] sh_a, sh_b;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
    end else begin
      busy_meta <= BUSY_ADC;
      busy_sync <= busy_meta;
    end
  end

  // Counter loads interval-1 so the next falling edge lands exactly 'interval' cycles later.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    ivl_sel    = (state == IDLE) ? interval : ivl_len;
    ivl_reload = (ivl_sel == 16'd0) ? 16'd0 : ivl_sel - 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      CNVST_ADC  <= 1'b1;
      CS_ADC     <= 1'b1;
      SCLK_ADC   <= 1'b1;
      data_a     <= '0;
      data_b     <= '0;
      data_valid <= 1'b0;
      rem        <= '0;
      ivl_len    <= '0;
      ivl_cnt    <= '0;
      tmr        <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      setup      <= 1'b0;
`ifdef ADC_SEQ_TESTPAT_EN
      sample_idx <= '0;
`else
      sh_a       <= '0;
      sh_b       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (ivl_cnt != 16'd0) ivl_cnt <= ivl_cnt - 16'd1;

      if (abort && state != IDLE) begin
        state      <= IDLE;
        running    <= 1'b0;
        done       <= 1'b1;
        CNVST_ADC  <= 1'b1;
        CS_ADC     <= 1'b1;
        SCLK_ADC   <= 1'b1;
        data_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            error <= 1'b0;
            if (n_samples == 16'd0) begin
              done <= 1'b1;
            end else begin
              running   <= 1'b1;
              rem       <= n_samples;
              ivl_len   <= interval;
`ifdef ADC_SEQ_TESTPAT_EN
              sample_idx <= '0;
`endif
              state     <= CONV;
              CNVST_ADC <= 1'b0;
              tmr       <= '0;
              ivl_cnt   <= ivl_reload;
            end
          end
          CONV: begin
            if (tmr == TMO_W'(CNVST_LOW - 1)) begin
              CNVST_ADC <= 1'b1;
              tmr       <= '0;
              state     <= WAIT_BH;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          WAIT_BH: begin
            if (busy_sync) begin
              tmr   <= '0;
              state <= WAIT_BL;
            end else if (tmr == TMO_W'(BUSY_TIMEOUT)) begin
              error <= 1'b1;
              state <= DONE;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          WAIT_BL: begin
            if (!busy_sync) begin
              CS_ADC  <= 1'b0;
              setup   <= 1'b1;
              div_cnt <= '0;
              bit_cnt <= '0;
              state   <= SHIFT;
            end else if (tmr == TMO_W'(BUSY_TIMEOUT)) begin
              error <= 1'b1;
              state <= DONE;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          SHIFT: begin
            if (setup) begin
              setup    <= 1'b0;
              SCLK_ADC <= 1'b0;
              div_cnt  <= '0;
            end else if (!SCLK_ADC) begin
              if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
                SCLK_ADC <= 1'b1;
                div_cnt  <= '0;
                bit_cnt  <= bit_cnt + 1'b1;
`ifndef ADC_SEQ_TESTPAT_EN
                sh_a     <= {sh_a[DATA_BITS-2:0], DOUTA_ADC};
                sh_b     <= {sh_b[DATA_BITS-2:0], DOUTB_ADC};
`endif
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end else if (bit_cnt == BIT_W'(DATA_BITS)) begin
              CS_ADC     <= 1'b1;
              data_valid <= 1'b1;
              state      <= OUT;
`ifdef ADC_SEQ_TESTPAT_EN
              data_a     <= sample_idx[DATA_BITS-1:0];
              data_b     <= ~sample_idx[DATA_BITS-1:0];
`else
              data_a     <= sh_a;
              data_b     <= sh_b;
`endif
            end else if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
              SCLK_ADC <= 1'b0;
              div_cnt  <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          OUT: if (data_ready) begin
            data_valid <= 1'b0;
            rem        <= rem - 16'd1;
`ifdef ADC_SEQ_TESTPAT_EN
            sample_idx <= sample_idx + 16'd1;
`endif
            if (rem == 16'd1) begin
              state <= DONE;
            end else if (ivl_cnt == 16'd0) begin
              state     <= CONV;
              CNVST_ADC <= 1'b0;
              tmr       <= '0;
              ivl_cnt   <= ivl_reload;
            end else begin
              state <= GAP;
            end
          end
          GAP: if (ivl_cnt == 16'd0) begin
            state     <= CONV;
            CNVST_ADC <= 1'b0;
            tmr       <= '0;
            ivl_cnt   <= ivl_reload;
          end
          DONE: begin
            done    <= 1'b1;
            running <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: ADC pin model plus expected-word queue, checked by a monitor.

module tb_adc_seq_ctrl;
  localparam int DB = 14;
  localparam int BUSY_TIMEOUT = 255;

  logic          CLK = 1'b0, RST_N = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0]   n_samples = '0, interval = '0;
  logic          running, done, error, CNVST_ADC, CS_ADC, SCLK_ADC;
  logic          BUSY_ADC = 1'b0, DOUTA_ADC = 1'b0, DOUTB_ADC = 1'b0;
  logic [DB-1:0] data_a, data_b;
  logic          data_valid, data_ready = 1'b1;

  adc_seq_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
    .n_samples(n_samples), .interval(interval), .running(running), .done(done),
    .error(error), .CNVST_ADC(CNVST_ADC), .CS_ADC(CS_ADC), .SCLK_ADC(SCLK_ADC),
    .BUSY_ADC(BUSY_ADC), .DOUTA_ADC(DOUTA_ADC), .DOUTB_ADC(DOUTB_ADC),
    .data_a(data_a), .data_b(data_b), .data_valid(data_valid), .data_ready(data_ready)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_fail = 0, cyc = 0;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ADC model: BUSY pulse after CNVST, MSB on CS fall, next bit after each SCLK rise
  bit            busy_en = 1'b1;
  int            busy_t = 740;
  logic [DB-1:0] mq_a[$], mq_b[$], exp_a[$], exp_b[$];
  logic [DB-1:0] cur_a = '0, cur_b = '0;
  int            bit_idx = 0;

  always @(negedge CNVST_ADC) if (busy_en && RST_N) begin
    #5 BUSY_ADC = 1'b1;
    #(busy_t) BUSY_ADC = 1'b0;
  end

  always @(negedge CS_ADC) begin
    if (mq_a.size() > 0) begin
      cur_a = mq_a.pop_front();
      cur_b = mq_b.pop_front();
    end else begin
      cur_a = '0;
      cur_b = '0;
    end
    bit_idx   = DB - 1;
    DOUTA_ADC = cur_a[bit_idx];
    DOUTB_ADC = cur_b[bit_idx];
  end

  always @(posedge SCLK_ADC) if (CS_ADC === 1'b0) begin
    #1;
    if (bit_idx > 0) bit_idx--;
    DOUTA_ADC = cur_a[bit_idx];
    DOUTB_ADC = cur_b[bit_idx];
  end

  // ---------------- ready driver: 0 = low, 1 = high, 2 = random per cycle
  int ready_mode = 1;
  initial forever begin
    @(posedge CLK);
    #1;
    case (ready_mode)
      0:       data_ready = 1'b0;
      1:       data_ready = 1'b1;
      default: data_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor / scoreboard
  int hs_cnt = 0, done_cnt = 0, sclk_falls = 0, sclk_rises = 0, cnv_falls = 0;
  int cnv_times[$], done_times[$];
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_sclk = 1'b1, prev_cnv = 1'b1;
  logic [DB-1:0] prev_a = '0, prev_b = '0;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (prev_sclk && !SCLK_ADC) sclk_falls++;
      if (!prev_sclk && SCLK_ADC) sclk_rises++;
      if (prev_cnv && !CNVST_ADC) begin
        cnv_falls++;
        cnv_times.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_times.push_back(cyc);
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(data_valid), 32'd1);
        check("hold_data_a", 32'(data_a), 32'(prev_a));
        check("hold_data_b", 32'(data_b), 32'(prev_b));
      end
      if (data_valid && data_ready) begin
        check("sb_has_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          check("data_a", 32'(data_a), 32'(exp_a.pop_front()));
          check("data_b", 32'(data_b), 32'(exp_b.pop_front()));
          hs_cnt++;
        end
      end
    end
    prev_valid = data_valid;
    prev_ready = data_ready;
    prev_sclk  = SCLK_ADC;
    prev_cnv   = CNVST_ADC;
    prev_a     = data_a;
    prev_b     = data_b;
  end

  // ---------------- stimulus helpers
  task automatic push_sample(input logic [DB-1:0] a, input logic [DB-1:0] b, input bit expect_it);
    mq_a.push_back(a);
    mq_b.push_back(b);
    if (expect_it) begin
      exp_a.push_back(a);
      exp_b.push_back(b);
    end
  endtask

  task automatic pulse_start(input int n, input int iv);
    @(posedge CLK);
    #1;
    n_samples = 16'(n);
    interval  = 16'(iv);
    start     = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    #1;
    check(name, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence
  initial begin
    int h0, f0, c0, r0, d0, k, n, iv;
    logic [DB-1:0] wa, wb;

    // Reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cnvst", 32'(CNVST_ADC), 32'd1);
    check("rst_cs", 32'(CS_ADC), 32'd1);
    check("rst_sclk", 32'(SCLK_ADC), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    check("idle_no_sclk", 32'(sclk_falls), 32'd0);
    check("idle_cnvst", 32'(CNVST_ADC), 32'd1);

    // Single conversion with fixed words
    h0 = hs_cnt; f0 = sclk_falls;
    push_sample(14'h2A5C, 14'h15A3, 1'b1);
    pulse_start(1, 0);
    check("single_running", 32'(running), 32'd1);
    wait_done("single_done", 400);
    repeat (3) @(negedge CLK);
    check("single_handshakes", 32'(hs_cnt - h0), 32'd1);
    check("single_sclk_falls", 32'(sclk_falls - f0), 32'd14);
    check("single_error", 32'(error), 32'd0);
    check("single_running_low", 32'(running), 32'd0);
    check("single_sb_empty", 32'(exp_a.size()), 32'd0);

    // Four samples, interval 200: falling edges exactly 200 apart
    h0 = hs_cnt; c0 = cnv_times.size();
    for (int i = 0; i < 4; i++) push_sample(DB'($urandom), DB'($urandom), 1'b1);
    pulse_start(4, 200);
    wait_done("ivl_done", 2000);
    check("ivl_cnv_count", 32'(cnv_times.size() - c0), 32'd4);
    if (cnv_times.size() - c0 >= 4)
      for (int i = 1; i < 4; i++)
        check("ivl_spacing", 32'(cnv_times[c0+i] - cnv_times[c0+i-1]), 32'd200);
    check("ivl_handshakes", 32'(hs_cnt - h0), 32'd4);

    // Backpressure: result held, no new conversion until accepted
    ready_mode = 0;
    h0 = hs_cnt; c0 = cnv_falls;
    for (int i = 0; i < 2; i++) push_sample(DB'($urandom), DB'($urandom), 1'b1);
    pulse_start(2, 50);
    k = 0;
    while (!data_valid && k < 400) begin
      @(negedge CLK);
      k++;
    end
    check("bp_valid_seen", 32'(data_valid), 32'd1);
    repeat (500) @(negedge CLK);
    check("bp_valid_held", 32'(data_valid), 32'd1);
    check("bp_no_new_cnvst", 32'(cnv_falls - c0), 32'd1);
    ready_mode = 1;
    wait_done("bp_done", 800);
    check("bp_handshakes", 32'(hs_cnt - h0), 32'd2);
    check("bp_cnvst_total", 32'(cnv_falls - c0), 32'd2);

    // BUSY stuck low: timeout, error, done, no serial activity
    busy_en = 1'b0;
    h0 = hs_cnt; f0 = sclk_falls; c0 = cnv_times.size(); d0 = done_times.size();
    pulse_start(3, 0);
    @(negedge CLK);
    #1;
    check("tmo_cnv_issued", 32'(cnv_times.size() - c0), 32'd1);
    repeat (200) @(negedge CLK);
    check("tmo_error_not_early", 32'(error), 32'd0);
    wait_done("tmo_done", 600);
    check("tmo_error", 32'(error), 32'd1);
    if (cnv_times.size() > c0 && done_times.size() > d0) begin
      k = done_times[d0] - cnv_times[c0];
      check("tmo_latency_window", 32'(k > BUSY_TIMEOUT && k <= BUSY_TIMEOUT + 6), 32'd1);
    end
    check("tmo_no_sclk", 32'(sclk_falls - f0), 32'd0);
    check("tmo_single_cnvst", 32'(cnv_times.size() - c0), 32'd1);
    check("tmo_no_data", 32'(hs_cnt - h0), 32'd0);
    busy_en = 1'b1;
    h0 = hs_cnt;
    push_sample(DB'($urandom), DB'($urandom), 1'b1);
    pulse_start(1, 0);
    check("tmo_error_cleared", 32'(error), 32'd0);
    wait_done("tmo_recover_done", 400);
    check("tmo_recover_data", 32'(hs_cnt - h0), 32'd1);

    // Abort during SHIFT after seven rising edges
    h0 = hs_cnt; r0 = sclk_rises;
    push_sample(DB'($urandom), DB'($urandom), 1'b0);
    pulse_start(1, 0);
    k = 0;
    while (sclk_rises - r0 < 7 && k < 400) begin
      @(negedge CLK);
      k++;
    end
    check("abort_reached_bit7", 32'(sclk_rises - r0), 32'd7);
    @(posedge CLK);
    #1 abort = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_cs", 32'(CS_ADC), 32'd1);
    check("abort_sclk", 32'(SCLK_ADC), 32'd1);
    check("abort_valid", 32'(data_valid), 32'd0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_running", 32'(running), 32'd0);
    abort = 1'b0;
    repeat (5) @(negedge CLK);
    check("abort_no_data", 32'(hs_cnt - h0), 32'd0);
    push_sample(DB'($urandom), DB'($urandom), 1'b1);
    pulse_start(1, 0);
    wait_done("abort_recover_done", 400);
    check("abort_recover_data", 32'(hs_cnt - h0), 32'd1);

    // n_samples == 0: immediate done, no conversion
    c0 = cnv_falls;
    pulse_start(0, 0);
    check("zero_running", 32'(running), 32'd0);
    wait_done("zero_done", 4);
    check("zero_no_cnvst", 32'(cnv_falls - c0), 32'd0);

    // Randomized sequences with random ready
    ready_mode = 2;
    for (int t = 0; t < 3; t++) begin
      n  = $urandom_range(1, 4);
      iv = $urandom_range(0, 300);
      h0 = hs_cnt; c0 = cnv_times.size();
      for (int i = 0; i < n; i++) push_sample(DB'($urandom), DB'($urandom), 1'b1);
      pulse_start(n, iv);
      wait_done("rand_done", 4000);
      check("rand_handshakes", 32'(hs_cnt - h0), 32'(n));
      for (int i = c0 + 1; i < cnv_times.size(); i++)
        check("rand_spacing_ge_interval", 32'(cnv_times[i] - cnv_times[i-1] >= iv), 32'd1);
    end
    ready_mode = 1;
    check("rand_sb_empty", 32'(exp_a.size()), 32'd0);

    // Reset asserted mid-sequence forces idle values at once
    push_sample(DB'($urandom), DB'($urandom), 1'b0);
    pulse_start(1, 0);
    k = 0;
    while (CS_ADC !== 1'b0 && k < 400) begin
      @(negedge CLK);
      k++;
    end
    check("midrst_in_shift", 32'(CS_ADC), 32'd0);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_cnvst", 32'(CNVST_ADC), 32'd1);
    check("midrst_cs", 32'(CS_ADC), 32'd1);
    check("midrst_sclk", 32'(SCLK_ADC), 32'd1);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_data_a", 32'(data_a), 32'd0);
    check("midrst_data_b", 32'(data_b), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    check("midrst_stays_idle", 32'(running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
- Sequences the dual-channel serial ADC on the memboard.
- Issues conversion starts on CNVST_ADC and tracks BUSY_ADC.
- Shifts out simultaneous channel A/B results over CS_ADC/SCLK_ADC/DOUTA_ADC/DOUTB_ADC.
- Delivers parallel A/B words to the host-interface FIFO logic through a valid/ready handshake; the sampling sequence is set by a start pulse, a sample count and an inter-sample interval.

Parameters:
DATA_BITS, 14, bits per channel per conversion, shifted MSB first
SCLK_DIV, 4, CLK cycles per SCLK half-period (minimum 2)
CNVST_LOW, 2, CLK cycles CNVST_ADC is held low per conversion
BUSY_TIMEOUT, 255, CLK cycles allowed for each BUSY_ADC phase before error

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sequence when idle
abort  in  1  one-cycle pulse; terminates the sequence
n_samples  in  16  conversions per sequence, sampled on start
interval  in  16  CLK cycles between successive CNVST_ADC falling edges, sampled on start
running  out  1  high from start acceptance until done or abort
done  out  1  one-cycle pulse when the sequence completes or aborts
error  out  1  sticky BUSY timeout flag, cleared on next accepted start
CNVST_ADC  out  1  conversion start, active low
CS_ADC  out  1  serial chip select, active low
SCLK_ADC  out  1  serial clock, idle high
BUSY_ADC  in  1  ADC busy, asynchronous to CLK
DOUTA_ADC  in  1  channel A serial data
DOUTB_ADC  in  1  channel B serial data
data_a  out  DATA_BITS  channel A result
data_b  out  DATA_BITS  channel B result
data_valid  out  1  result available
data_ready  in  1  consumer accepts the result when data_valid and data_ready are both high

Behaviour:
- Reset values: CNVST_ADC=1, CS_ADC=1, SCLK_ADC=1, running=0, done=0, error=0, data_valid=0, data_a=0, data_b=0. RST_N low mid-sequence forces these values immediately.
- BUSY_ADC passes through a 2-flop synchronizer; all BUSY decisions use the synchronized value, giving 2 cycles of latency.
- States:
  - IDLE: start accepted, n_samples latched, running goes high.
    - If n_samples==0: done pulses the next cycle, no conversion is issued, running stays low.
  - CONV: CNVST_ADC low for CNVST_LOW cycles. The interval counter reloads on CNVST falling.
  - WAIT_BH: wait for synchronized BUSY high.
  - WAIT_BL: wait for synchronized BUSY low.
  - SHIFT:
    - CS_ADC low for 1 setup cycle.
    - Then DATA_BITS SCLK periods: low SCLK_DIV cycles, then high SCLK_DIV cycles.
    - DOUTA/DOUTB sampled on the CLK edge where SCLK_ADC rises, MSB first.
    - CS_ADC high 1 cycle after the last rising edge.
  - OUT: data_a/data_b loaded, data_valid high; held stable until accepted.
  - GAP: wait until the interval counter expires, then go to CONV.
    - Go to DONE instead if the sample count is reached.
    - interval shorter than the conversion+shift time means the next CONV follows acceptance immediately.
  - DONE: done pulses, running low, return to IDLE.
- Timeout: more than BUSY_TIMEOUT cycles in WAIT_BH or WAIT_BL sets error and ends the sequence via DONE.
- Backpressure: no new CNVST_ADC is issued while data_valid is high.
- Interval counter: 16-bit down counter, saturates at 0.
- start while running is ignored. n_samples=65535 yields exactly 65535 conversions, with no counter wrap.
- abort in any non-IDLE state:
  - Next cycle: CNVST_ADC=1, CS_ADC=1, SCLK_ADC=1, data_valid=0, done pulse, state IDLE.
  - Partial data is discarded.
  - abort and start in the same IDLE cycle: start is ignored.

Optional Feature:
- Macro ADC_SEQ_TESTPAT_EN.
- Defined:
  - data_a = sample index (0-based, truncated to DATA_BITS).
  - data_b = bitwise inverse of data_a.
  - Pin sequencing and timing are unchanged; DOUT inputs are ignored.
- Undefined: data comes from the shifted serial bits.

Test Plan:
- Reset: hold RST_N low, then release -> all outputs at reset values; no SCLK_ADC edges.
- Single conversion, DOUT streams 14'h2A5C/14'h15A3, n_samples=1, data_ready=1 -> data_a=14'h2A5C, data_b=14'h15A3. Exactly 14 SCLK falling edges, one done pulse, error=0.
- n_samples=4, interval=200, ADC model with BUSY 740 ns -> CNVST_ADC falling edges exactly 200 cycles apart, 4 data_valid handshakes, then done.
- data_ready held low for 500 cycles after the first sample -> data stable; no second CNVST_ADC until acceptance.
- BUSY_ADC stuck low, n_samples=3 -> error=1 after 255 cycles in WAIT_BH, done pulse, no SCLK_ADC activity. The next start clears error.
- abort during SHIFT at bit 7 -> next cycle CS_ADC=1, SCLK_ADC=1, data_valid stays 0, done pulses. A new start then completes normally.
